// File: rtl/reg_file.sv
// 32 x 32 general-purpose register file: two combinational read ports with
// write-through bypass, one synchronous write port, r0 hardwired to zero.
module reg_file #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic          wreg,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0] regs [NREG];
    logic          wr_active;
    logic          hit1;
    logic          hit2;

    // A write is only live outside reset, which also gates the bypass.
    assign wr_active = wreg && resetn;
    assign hit1      = wr_active && (waddr == raddr1);
    assign hit2      = wr_active && (waddr == raddr2);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wreg && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (hit1) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (hit2) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_reg_file;

    logic        clk;
    logic        resetn;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    logic [31:0] mdl [32];
    int checks;
    int errors;

    reg_file #(.DW(32), .AW(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .wreg   (wreg),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value from the architectural rules.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (!resetn) return 32'h0;
        if (wreg && waddr == a) return wdata;
        return mdl[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endtask

    // Advance one rising edge, updating the model first; returns #1 after it.
    task automatic step();
        if (resetn && wreg && waddr != 5'd0) mdl[waddr] = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        wreg = 1'b0; waddr = 5'd0; wdata = 32'h0;
        raddr1 = 5'd0; raddr2 = 5'd0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            checks++;
            if (rdata1 !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", i, rdata1, 32'h0);
            end
            checks++;
            if (rdata2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd2 addr=%0d got=%h exp=%h", 31 - i, rdata2, 32'h0);
            end
        end
    endtask

    task automatic test_write_read();
        wreg = 1'b1; waddr = 5'd5; wdata = 32'h1;
        step();
        wreg = 1'b0; raddr1 = 5'd5;
        #1;
        checks++;
        if (rdata1 !== 32'h1) begin
            errors++;
            $display("FAIL write_read got=%h exp=%h", rdata1, 32'h1);
        end
    endtask

    task automatic test_bypass();
        wreg = 1'b1; waddr = 5'd6; wdata = 32'h10; raddr1 = 5'd6;
        #1;
        checks++;
        if (rdata1 !== 32'h10) begin
            errors++;
            $display("FAIL bypass_pre got=%h exp=%h", rdata1, 32'h10);
        end
        step();
        wreg = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h10) begin
            errors++;
            $display("FAIL bypass_post got=%h exp=%h", rdata1, 32'h10);
        end
    endtask

    task automatic test_zero_reg();
        wreg = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_during got=%h/%h exp=%h", rdata1, rdata2, 32'h0);
        end
        step();
        wreg = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_after got=%h/%h exp=%h", rdata1, rdata2, 32'h0);
        end
    endtask

    task automatic test_dual_read();
        wreg = 1'b0; raddr1 = 5'd5; raddr2 = 5'd6;
        #1;
        checks++;
        if (rdata1 !== 32'h1 || rdata2 !== 32'h10) begin
            errors++;
            $display("FAIL dual_read got=%h/%h exp=%h/%h", rdata1, rdata2, 32'h1, 32'h10);
        end
        wreg = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
        step();
        wreg = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h1 || rdata2 !== 32'h10) begin
            errors++;
            $display("FAIL no_corrupt got=%h/%h exp=%h/%h", rdata1, rdata2, 32'h1, 32'h10);
        end
        raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        checks++;
        if (rdata1 !== 32'hDEAD_BEEF || rdata2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL r7_read got=%h/%h exp=%h", rdata1, rdata2, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_async_reset();
        wreg = 1'b1; waddr = 5'd5; wdata = 32'h1;
        step();
        wreg = 1'b0; raddr1 = 5'd5; raddr2 = 5'd7;
        #1;
        checks++;
        if (rdata1 !== 32'h1) begin
            errors++;
            $display("FAIL async_pre got=%h exp=%h", rdata1, 32'h1);
        end
        // Drop reset well before the next rising edge.
        #1;
        resetn = 1'b0;
        model_clear();
        #1;
        checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL async_clear got=%h/%h exp=%h", rdata1, rdata2, 32'h0);
        end
        wreg = 1'b1; waddr = 5'd9; wdata = 32'hCAFE_F00D; raddr1 = 5'd9;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_bypass got=%h exp=%h", rdata1, 32'h0);
        end
        step();
        wreg = 1'b0;
        #1;
        resetn = 1'b1;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_write_lost got=%h exp=%h", rdata1, 32'h0);
        end
        wreg = 1'b1; waddr = 5'd5; wdata = 32'h55;
        step();
        wreg = 1'b0; raddr1 = 5'd5;
        #1;
        checks++;
        if (rdata1 !== 32'h55) begin
            errors++;
            $display("FAIL post_reset_write got=%h exp=%h", rdata1, 32'h55);
        end
    endtask

    task automatic test_back_to_back();
        wreg = 1'b1; waddr = 5'd12; wdata = 32'h1111_1111;
        step();
        wdata = 32'h2222_2222;
        step();
        wreg = 1'b0; raddr1 = 5'd12;
        #1;
        checks++;
        if (rdata1 !== 32'h2222_2222) begin
            errors++;
            $display("FAIL back_to_back got=%h exp=%h", rdata1, 32'h2222_2222);
        end
    endtask

    task automatic test_random();
        logic [31:0] e1;
        logic [31:0] e2;
        for (int n = 0; n < 400; n++) begin
            wreg  = ($urandom_range(0, 3) != 0);
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            #1;
            e1 = exp_rd(raddr1);
            e2 = exp_rd(raddr2);
            checks++;
            if (rdata1 !== e1) begin
                errors++;
                $display("FAIL rand_rd1 it=%0d addr=%0d got=%h exp=%h", n, raddr1, rdata1, e1);
            end
            checks++;
            if (rdata2 !== e2) begin
                errors++;
                $display("FAIL rand_rd2 it=%0d addr=%0d got=%h exp=%h", n, raddr2, rdata2, e2);
            end
            step();
        end
        wreg = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            #1;
            e1 = (i == 0) ? 32'h0 : mdl[i];
            checks++;
            if (rdata1 !== e1) begin
                errors++;
                $display("FAIL rand_final addr=%0d got=%h exp=%h", i, rdata1, e1);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_dual_read();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
